sun2_intr_req: RTL and testbench

Interrupt request front end for the Sun-2 CPU board. Synchronizes the seven active-low interrupt request lines, latches edge-type sources, merges the software interrupt/enable register, and drives the active-low 8-bit request vector consumed by the downstream 8-to-3 priority encoder. Also runs the interrupt acknowledge handshake: it clears the acknowledged level's pending latch and reports autovector or spurious status to the bus controller.

---
 rtl/sun2_intr_req.sv | 141 ++++++++++++++
 tb/tb_sun2_intr_req.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sun2_intr_req.sv
// Sun-2 interrupt request front end. It synchronizes the active-low irq lines,
// latches the edge-type levels, and merges in the software/enable register.
// It drives the active-low request vector for the priority encoder and runs
// the interrupt acknowledge handshake.
module sun2_intr_req #(
  parameter logic [7:0]  EDGE_MASK   = 8'h00,
  parameter int unsigned SYNC_STAGES = 2       // legal range 2..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] irq_n,
  input  logic       en_we,
  input  logic [3:0] en_wdata,
  output logic [3:0] en_q,
  output logic [7:0] req_n,
  input  logic       iack,
  input  logic [2:0] iack_level,
  output logic       iack_done,
  output logic       avec,
  output logic       spurious
);

  typedef enum logic [1:0] {StIdle, StClear, StDone, StWait} state_e;

  // Bit 0 of the mask is ignored; level 0 never exists.
  localparam logic [7:0] EdgeMask = {EDGE_MASK[7:1], 1'b0};

  logic [6:0] sync_q [SYNC_STAGES];
  logic [7:0] s;
  logic [7:0] s_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] set_w, clr_w;
  logic [7:0] act;
  logic [7:0] gate;
  logic [7:0] req_q, req_d;
  logic [3:0] en_reg_q;

  state_e     state_q;
  logic [2:0] lvl_q;
  logic       hit_q;
  logic       iack_prev_q;
  logic       iack_done_q, avec_q, spurious_q;

  // Synchronizer chain for the asynchronous request lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '1;
    end else begin
      sync_q[0] <= irq_n;
      for (int unsigned j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  assign s = {~sync_q[SYNC_STAGES-1], 1'b0};

  // s_q is both the level-type request and the previous sample for edge detect,
  // so level and edge sources see the same latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_q <= '0;
    else       s_q <= s;
  end

  // Pending latches: the acknowledge clear uses the captured level in DONE.
  // A simultaneous set overrides the clear.
  always_comb begin
    set_w  = EdgeMask & s & ~s_q;
    clr_w  = (state_q == StDone) ? ((8'h01 << lvl_q) & EdgeMask) : 8'h00;
    pend_d = (pend_q & ~clr_w) | set_w;
  end

  // Pending latch state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Ungated requests, the gate mask, and the next request vector.
  always_comb begin
    act   = ((EdgeMask & pend_q) | (~EdgeMask & s_q)) | {4'b0000, en_reg_q[3:1], 1'b0};
    // Level 7 is NMI and is never masked.
    gate  = {1'b1, {6{en_reg_q[0]}}, 1'b0};
    req_d = ~(act & gate) | 8'h01;
  end

  // Registered request vector and enable register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= 8'hFF;
      en_reg_q <= 4'h0;
    end else begin
      req_q <= req_d;
      if (en_we) en_reg_q <= en_wdata;
    end
  end

  // Acknowledge handshake FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      lvl_q       <= 3'd0;
      hit_q       <= 1'b0;
      // Held high so an iack still asserted after reset is not seen as a rise.
      iack_prev_q <= 1'b1;
      iack_done_q <= 1'b0;
      avec_q      <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      iack_prev_q <= iack;
      iack_done_q <= 1'b0;
      avec_q      <= 1'b0;
      spurious_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iack && !iack_prev_q) state_q <= StClear;
        end
        StClear: begin
          lvl_q   <= iack_level;
          hit_q   <= (iack_level != 3'd0) && act[iack_level];
          state_q <= StDone;
        end
        StDone: begin
          iack_done_q <= 1'b1;
          avec_q      <= hit_q;
          spurious_q  <= ~hit_q;
          state_q     <= iack ? StWait : StIdle;
        end
        StWait: begin
          if (!iack) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_q      = en_reg_q;
  assign req_n     = req_q;
  assign iack_done = iack_done_q;
  assign avec      = avec_q;
  assign spurious  = spurious_q;

endmodule

// File: tb/tb_sun2_intr_req.sv
// Directed testbench for sun2_intr_req with level 6 configured as edge-type.
module tb_sun2_intr_req;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] irq_n;
  logic       en_we;
  logic [3:0] en_wdata;
  logic [3:0] en_q;
  logic [7:0] req_n;
  logic       iack;
  logic [2:0] iack_level;
  logic       iack_done;
  logic       avec;
  logic       spurious;

  int tests = 0;
  int fails = 0;

  sun2_intr_req #(
    .EDGE_MASK  (8'h40),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_n     (irq_n),
    .en_we     (en_we),
    .en_wdata  (en_wdata),
    .en_q      (en_q),
    .req_n     (req_n),
    .iack      (iack),
    .iack_level(iack_level),
    .iack_done (iack_done),
    .avec      (avec),
    .spurious  (spurious)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_ack(input string tag, input logic d, input logic a, input logic s);
    check1({tag, "_done"}, iack_done, d);
    check1({tag, "_avec"}, avec, a);
    check1({tag, "_spur"}, spurious, s);
  endtask

  initial begin
    reset      = 1'b1;
    irq_n      = 7'h7F;
    en_we      = 1'b0;
    en_wdata   = 4'h0;
    iack       = 1'b0;
    iack_level = 3'd0;
    tick(2);
    check8("rst_req", req_n, 8'hFF);
    check8("rst_en", {4'h0, en_q}, 8'h00);
    check_ack("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1);

    // Enable on.
    en_we = 1'b1; en_wdata = 4'h1;
    tick(1);
    en_we = 1'b0;
    check8("en_wr1", {4'h0, en_q}, 8'h01);

    // Level 3, level type: sampled at edge k, req_n changes at k+3.
    irq_n = 7'h7B;
    tick(3);
    check8("lv3_early", req_n, 8'hFF);
    tick(1);
    check8("lv3_on", req_n, 8'hF7);
    irq_n = 7'h7F;
    tick(3);
    check8("lv3_hold", req_n, 8'hF7);
    tick(1);
    check8("lv3_off", req_n, 8'hFF);

    // Level 6 edge: one-clock pulse latches.
    irq_n = 7'h5F;
    tick(1);
    irq_n = 7'h7F;
    tick(2);
    check8("lv6_early", req_n, 8'hFF);
    tick(1);
    check8("lv6_set", req_n, 8'hBF);
    tick(5);
    check8("lv6_hold", req_n, 8'hBF);

    // Acknowledge level 6.
    iack = 1'b1; iack_level = 3'd6;
    tick(2);
    check_ack("ack6_clr", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_ack("ack6", 1'b1, 1'b1, 1'b0);
    check8("ack6_req_k2", req_n, 8'hBF);
    iack = 1'b0;
    tick(1);
    check_ack("ack6_after", 1'b0, 1'b0, 1'b0);
    check8("ack6_req_k3", req_n, 8'hFF);

    // Enable off, levels 5 and 7 asserted: only NMI passes.
    en_we = 1'b1; en_wdata = 4'h0;
    tick(1);
    en_we = 1'b0;
    irq_n = 7'h2F;
    tick(4);
    check8("mask_nmi", req_n, 8'h7F);
    en_we = 1'b1; en_wdata = 4'h1;
    tick(1);
    en_we = 1'b0;
    check8("unmask_k1", req_n, 8'h7F);
    tick(1);
    check8("unmask_k2", req_n, 8'h5F);

    // Acknowledge level 4: nothing requesting.
    iack = 1'b1; iack_level = 3'd4;
    tick(3);
    check_ack("ack4", 1'b1, 1'b0, 1'b1);
    iack = 1'b0;
    tick(1);
    check_ack("ack4_after", 1'b0, 1'b0, 1'b0);

    // Acknowledge level 0: always spurious.
    iack = 1'b1; iack_level = 3'd0;
    tick(3);
    check_ack("ack0", 1'b1, 1'b0, 1'b1);
    iack = 1'b0;
    tick(1);

    // Acknowledge level 5 (level type): avec, nothing cleared.
    iack = 1'b1; iack_level = 3'd5;
    tick(3);
    check_ack("ack5", 1'b1, 1'b1, 1'b0);
    iack = 1'b0;
    tick(2);
    check8("ack5_req", req_n, 8'h5F);

    irq_n = 7'h7F;
    tick(5);
    check8("release57", req_n, 8'hFF);

    // Set wins over clear for level 6.
    irq_n = 7'h5F;
    tick(1);
    irq_n = 7'h7F;
    tick(4);
    check8("lv6_reset", req_n, 8'hBF);
    // New edge and iack rise sampled on the same edge k: both land at k+2.
    irq_n = 7'h5F; iack = 1'b1; iack_level = 3'd6;
    tick(1);
    irq_n = 7'h7F;
    tick(2);
    check_ack("setwin", 1'b1, 1'b1, 1'b0);
    iack = 1'b0;
    tick(1);
    check8("setwin_req", req_n, 8'hBF);
    tick(3);
    check8("setwin_hold", req_n, 8'hBF);
    iack = 1'b1;
    tick(3);
    check_ack("ack6b", 1'b1, 1'b1, 1'b0);
    iack = 1'b0;
    tick(1);
    check8("ack6b_req", req_n, 8'hFF);

    // Software levels 1 and 3.
    en_we = 1'b1; en_wdata = 4'hB;
    tick(1);
    en_we = 1'b0;
    check8("en_wrB", {4'h0, en_q}, 8'h0B);
    tick(1);
    check8("sw13", req_n, 8'hF5);

    // Reset while in DONE.
    iack = 1'b1; iack_level = 3'd1;
    tick(2);
    reset = 1'b1;
    #1;
    check_ack("rst_mid", 1'b0, 1'b0, 1'b0);
    check8("rst_mid_req", req_n, 8'hFF);
    check8("rst_mid_en", {4'h0, en_q}, 8'h00);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check1("held_iack", iack_done, 1'b0);
    end
    iack = 1'b0;
    tick(1);
    iack = 1'b1;
    tick(3);
    check_ack("reack", 1'b1, 1'b0, 1'b1);
    iack = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
